// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard and stall sequencer for a 5-stage LEGv8 pipeline. It detects
// load-use hazards that forwarding cannot resolve and inserts one bubble for
// each. It flushes IF/ID and ID/EX on a taken branch. While data memory is not
// ready, it freezes the whole pipeline. It also keeps saturating statistics and
// a sticky memory-timeout flag.
//
// Ports
//   clk            pipeline clock. All state changes on the rising edge.
//   reset          asynchronous, active-low reset.
//   id_rn/id_rm    source registers of the instruction in ID.
//   id_uses_rn/rm  the ID instruction actually reads that source.
//   ex_mem_read    the EX instruction is a load (LDUR).
//   ex_rd          destination register of the EX instruction.
//   ex_br_taken    the branch in EX resolved taken this cycle.
//   mem_req        the MEM-stage instruction accesses data memory.
//   mem_ready      data memory completes the access this cycle.
//   pc_write       PC load enable.
//   if_id_write    IF/ID load enable.
//   pipe_hold      ID/EX and EX/MEM hold their contents.
//   id_ex_bubble   load NOP controls into ID/EX.
//   mem_wb_bubble  load NOP controls into MEM/WB.
//   if_id_flush    clear IF/ID.
//   id_ex_flush    clear ID/EX.
//   mem_err        sticky flag. Memory stayed busy for MEM_TIMEOUT cycles.
//   stall_cnt      saturating count of cycles with pc_write low.
//   flush_cnt      saturating count of branch flush cycles.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             pipe_hold,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // Hazard conditions, evaluated every cycle in either state.
    logic mem_wait;
    logic load_use;
    logic br_flush;

    assign mem_wait = mem_req && !mem_ready;

    // X31 reads as zero (XZR), so a load targeting it never feeds a consumer.
    assign load_use = ex_mem_read && (ex_rd != 5'd31) &&
                      ((id_uses_rn && (id_rn == ex_rd)) ||
                       (id_uses_rm && (id_rm == ex_rd)));

    // A memory wait holds EX, so the branch is acted on once memory completes.
    assign br_flush = ex_br_taken && !mem_wait;

    // ---------------------------------------------------------------- state
    // NOTE: sequential state is written with non-blocking assignments only.
    // Therefore every flop samples the values from before the edge, whatever
    // order the statements appear in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: default first, so that every path assigns the signal and no
        // latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_RUN:      if (mem_wait)  state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (!mem_wait) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------- outputs
    // The control outputs are identical in both states. Only the live wait
    // condition matters, so reset and RUN produce the same defaults.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        pipe_hold     = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        if (mem_wait) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            pipe_hold     = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (br_flush) begin
            // The PC keeps loading so that it takes the branch target. Any
            // load-use hazard is moot because the ID instruction is squashed.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // --------------------------------------------- wait counter and stats
    always_comb begin
        wait_cnt_d  = '0;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // Each edge taken with memory still busy counts as one wait cycle.
        // The flag sets on the edge where the count reaches MEM_TIMEOUT.
        if (state_d == ST_MEM_WAIT) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_q >= WAIT_LAST) mem_err_d = 1'b1;
        end

        if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (br_flush && (flush_cnt_q != '1))  flush_cnt_d = flush_cnt_q + 1'b1;
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
